// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Memory-stage load/store unit of an RV32I pipeline. Launches one data-memory
//   transaction per load/store over a request/ready bus, stalls the pipeline
//   while the transaction is outstanding, and returns the sign- or
//   zero-extended load result.
//
// Handshake: MemReq and every bus output (MemWE, MemAddr, MemByteEn,
//   MemWData) are registered and stay constant from the cycle after launch
//   until and including the cycle MemReady is sampled high. A cycle with
//   MemReq=1 and MemReady=1 completes the transfer; read data on MemRData is
//   valid in that same cycle. MemReq is never asserted in DONE or IDLE.
//
// Ports:
//   CLK, RST              clock, asynchronous active-low reset
//   ALUResultM            effective byte address
//   WriteDataM            store source data
//   Funct3M               access type (B/H/W/BU/HU; 011/110/111 act as W)
//   MemReadM, MemWriteM   load / store in M (store wins if both)
//   FlushM                kill the M instruction before launch
//   MemReq..MemWData      data bus request side
//   MemReady, MemRData    data bus response side
//   ReadDataM, DataValidM extended load result and completion pulse
//   StallM                freeze F/D/E/M
//   MisalignedM           misaligned-access pulse (IDLE only, combinational)
//   DbgStateM             current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic [2:0]        Funct3M,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic              FlushM,
  output logic              MemReq,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [3:0]        MemByteEn,
  output logic [31:0]       MemWData,
  input  logic              MemReady,
  input  logic [31:0]       MemRData,
  output logic [31:0]       ReadDataM,
  output logic              DataValidM,
  output logic              StallM,
  output logic              MisalignedM,
  output logic [1:0]        DbgStateM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic        access;
  logic        misaligned;
  logic        launch;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // ---------------------------------------------------------------------------
  // Access decode from the M-stage inputs. Funct3[1:0] gives the size
  // (00 byte, 01 half, anything else word); Funct3[2] selects zero-extension.
  // ---------------------------------------------------------------------------
  always_comb begin
    access     = (MemReadM | MemWriteM) & ~FlushM;
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wd_calc    = WriteDataM;
    unique case (Funct3M[1:0])
      2'b00: begin
        be_calc = 4'b0001 << ALUResultM[1:0];
        wd_calc = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        misaligned = ALUResultM[0];
        be_calc    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wd_calc    = {2{WriteDataM[15:0]}};
      end
      default: begin
        misaligned = (ALUResultM[1:0] != 2'b00);
      end
    endcase
    launch = (state_q == IDLE) & access & ~misaligned;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. DONE always returns to IDLE so the instruction still
  // sitting in M during DONE cannot relaunch. FlushM has no effect once BUSY.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch)   state_d = BUSY;
      BUSY:    if (MemReady) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: combinational outputs. Gated with RST so nothing is claimed while
  // the block is held in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    StallM      = RST & (launch | (state_q == BUSY));
    MisalignedM = RST & (state_q == IDLE) & access & misaligned;
    DbgStateM   = state_q;
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the captured byte offset and access type.
  // ---------------------------------------------------------------------------
  always_comb begin
    lane = MemRData >> {offset_q, 3'b000};
    unique case (funct3_q[1:0])
      2'b00:   load_ext = funct3_q[2] ? {24'd0, lane[7:0]}
                                      : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = funct3_q[2] ? {16'd0, lane[15:0]}
                                      : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = MemRData;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered bus side and result. MemReq/DataValidM are registered decodes
  // of the next state, so they line up exactly with BUSY/DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MemReq     <= 1'b0;
      MemWE      <= 1'b0;
      MemAddr    <= '0;
      MemByteEn  <= 4'b0000;
      MemWData   <= 32'd0;
      ReadDataM  <= 32'd0;
      DataValidM <= 1'b0;
      funct3_q   <= 3'b000;
      offset_q   <= 2'b00;
    end else begin
      MemReq     <= (state_d == BUSY);
      DataValidM <= (state_d == DONE);
      if (launch) begin
        MemWE     <= MemWriteM;
        MemAddr   <= {ALUResultM[ADDR_W-1:2], 2'b00};
        MemByteEn <= be_calc;
        MemWData  <= wd_calc;
        funct3_q  <= Funct3M;
        offset_q  <= ALUResultM[1:0];
      end
      // Stores leave the previous load result untouched.
      if ((state_q == BUSY) && MemReady && !MemWE) begin
        ReadDataM <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed bench for mem_access_stage. Driver tasks issue loads/stores with
//   hand-computed bus values and checks each cycle of the handshake; the
//   expected load result of every launched access goes into exp_q and a
//   separate monitor pops and compares it whenever DataValidM pulses.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        CLK;
  logic        RST;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  Funct3M;
  logic        MemReadM;
  logic        MemWriteM;
  logic        FlushM;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWData;
  logic        MemReady;
  logic [31:0] MemRData;
  logic [31:0] ReadDataM;
  logic        DataValidM;
  logic        StallM;
  logic        MisalignedM;
  logic [1:0]  DbgStateM;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  mem_access_stage #(.ADDR_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .Funct3M    (Funct3M),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .FlushM     (FlushM),
    .MemReq     (MemReq),
    .MemWE      (MemWE),
    .MemAddr    (MemAddr),
    .MemByteEn  (MemByteEn),
    .MemWData   (MemWData),
    .MemReady   (MemReady),
    .MemRData   (MemRData),
    .ReadDataM  (ReadDataM),
    .DataValidM (DataValidM),
    .StallM     (StallM),
    .MisalignedM(MisalignedM),
    .DbgStateM  (DbgStateM)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge CLK) begin
    if (DataValidM === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else                   chk("read_data", ReadDataM, exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks. Each starts 1 time unit after a rising edge (cycle T) and
  // returns at the same phase of the cycle after the access has retired.
  // ---------------------------------------------------------------------------
  task automatic drop_inputs();
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    FlushM    = 1'b0;
    MemReady  = 1'b0;
  endtask

  task automatic access(input string name, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic wr, input logic also_rd,
                        input int waits, input logic [31:0] exp_rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic flush_busy);
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    MemReadM   = ~wr | also_rd;
    MemWriteM  = wr;
    FlushM     = 1'b0;
    MemReady   = 1'b0;
    exp_q.push_back(wr ? last_rd : exp_rd);
    if (!wr) last_rd = exp_rd;
    @(negedge CLK);
    chk({name, "_launch_stall"}, {31'd0, StallM}, 32'd1);
    chk({name, "_launch_req"}, {31'd0, MemReq}, 32'd0);
    chk({name, "_launch_mis"}, {31'd0, MisalignedM}, 32'd0);
    for (int i = 0; i <= waits; i++) begin
      @(posedge CLK); #1;
      MemReady = (i == waits);
      MemRData = (i == waits) ? rd : 32'h0BAD_0BAD;
      FlushM   = flush_busy;
      @(negedge CLK);
      chk({name, "_busy_req"}, {31'd0, MemReq}, 32'd1);
      chk({name, "_busy_we"}, {31'd0, MemWE}, {31'd0, wr});
      chk({name, "_busy_addr"}, MemAddr, {addr[31:2], 2'b00});
      chk({name, "_busy_be"}, {28'd0, MemByteEn}, {28'd0, exp_be});
      if (wr) chk({name, "_busy_wdata"}, MemWData, exp_wd);
      chk({name, "_busy_stall"}, {31'd0, StallM}, 32'd1);
      chk({name, "_busy_valid"}, {31'd0, DataValidM}, 32'd0);
    end
    @(posedge CLK); #1;
    MemReady = 1'b0;
    FlushM   = 1'b0;
    @(negedge CLK);
    chk({name, "_done_valid"}, {31'd0, DataValidM}, 32'd1);
    chk({name, "_done_stall"}, {31'd0, StallM}, 32'd0);
    chk({name, "_done_req"}, {31'd0, MemReq}, 32'd0);
    @(posedge CLK); #1;
    drop_inputs();
    @(negedge CLK);
    chk({name, "_idle_req"}, {31'd0, MemReq}, 32'd0);
    chk({name, "_idle_valid"}, {31'd0, DataValidM}, 32'd0);
    @(posedge CLK); #1;
  endtask

  // Presents an access that must not launch (misaligned or flushed).
  task automatic no_launch(input string name, input logic [2:0] f3,
                           input logic [31:0] addr, input logic wr,
                           input logic flush, input logic exp_mis);
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = 32'h5555_AAAA;
    MemReadM   = ~wr;
    MemWriteM  = wr;
    FlushM     = flush;
    @(negedge CLK);
    chk({name, "_mis"}, {31'd0, MisalignedM}, {31'd0, exp_mis});
    chk({name, "_stall"}, {31'd0, StallM}, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk({name, "_req"}, {31'd0, MemReq}, 32'd0);
    @(posedge CLK); #1;
    drop_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    RST        = 1'b0;
    ALUResultM = 32'h0000_0100;
    WriteDataM = 32'd0;
    Funct3M    = 3'b010;
    MemReadM   = 1'b1;
    MemWriteM  = 1'b0;
    FlushM     = 1'b0;
    MemReady   = 1'b0;
    MemRData   = 32'd0;
    last_rd    = 32'd0;

    // Reset held with a load present.
    repeat (2) @(negedge CLK);
    chk("rst_req", {31'd0, MemReq}, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_valid", {31'd0, DataValidM}, 32'd0);
    chk("rst_state", {30'd0, DbgStateM}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;

    //      name      f3      addr          wd            rd            wr  both waits exp_rd        be       exp_wd        flush
    access("lw100",  3'b010, 32'h0000_0100, 32'd0,        32'h1234_5678, 0, 0, 0, 32'h1234_5678, 4'b1111, 32'd0,        0);
    access("lb1003", 3'b000, 32'h0000_1003, 32'd0,        32'h80FF_1234, 0, 0, 0, 32'hFFFF_FF80, 4'b1000, 32'd0,        0);
    access("lbu1003",3'b100, 32'h0000_1003, 32'd0,        32'h80FF_1234, 0, 0, 0, 32'h0000_0080, 4'b1000, 32'd0,        0);
    access("sh2002", 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'd0,        1, 0, 3, 32'd0,        4'b1100, 32'hBEEF_BEEF, 0);
    access("lh2002", 3'b001, 32'h0000_2002, 32'd0,        32'h8001_7FFF, 0, 0, 1, 32'hFFFF_8001, 4'b1100, 32'd0,        0);
    access("lhu2000",3'b101, 32'h0000_2000, 32'd0,        32'h8001_F00D, 0, 0, 0, 32'h0000_F00D, 4'b0011, 32'd0,        0);
    access("lb1001", 3'b000, 32'h0000_1001, 32'd0,        32'h0000_7F00, 0, 0, 0, 32'h0000_007F, 4'b0010, 32'd0,        0);
    access("sb1001", 3'b000, 32'h0000_1001, 32'h1234_56AB, 32'd0,        1, 0, 0, 32'd0,        4'b0010, 32'hABAB_ABAB, 0);
    access("sw3000f",3'b010, 32'h0000_3000, 32'hA5A5_0F0F, 32'd0,        1, 0, 2, 32'd0,        4'b1111, 32'hA5A5_0F0F, 1);
    access("lw_f",   3'b010, 32'h0000_3010, 32'd0,        32'h7654_3210, 0, 0, 1, 32'h7654_3210, 4'b1111, 32'd0,        1);
    access("both_sw",3'b010, 32'h0000_3008, 32'h0102_0304, 32'd0,        1, 1, 0, 32'd0,        4'b1111, 32'h0102_0304, 0);
    access("w011",   3'b011, 32'h0000_3004, 32'd0,        32'h1122_3344, 0, 0, 0, 32'h1122_3344, 4'b1111, 32'd0,        0);

    //        name          f3      addr           wr flush mis
    no_launch("mis_lw3001", 3'b010, 32'h0000_3001, 0, 0,    1);
    no_launch("mis_lh3001", 3'b001, 32'h0000_3001, 0, 0,    1);
    no_launch("mis_hu3003", 3'b101, 32'h0000_3003, 0, 0,    1);
    no_launch("mis_w111",   3'b111, 32'h0000_3002, 0, 0,    1);
    no_launch("flush_sw",   3'b010, 32'h0000_4000, 1, 1,    0);

    // Reset while BUSY: the request must drop without waiting for a clock.
    Funct3M    = 3'b010;
    ALUResultM = 32'h0000_0050;
    MemReadM   = 1'b1;
    MemWriteM  = 1'b0;
    MemReady   = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstbusy_req_before", {31'd0, MemReq}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("rstbusy_req_async", {31'd0, MemReq}, 32'd0);
    chk("rstbusy_be_async", {28'd0, MemByteEn}, 32'd0);
    chk("rstbusy_stall", {31'd0, StallM}, 32'd0);
    drop_inputs();
    @(posedge CLK); #1;
    RST     = 1'b1;
    last_rd = 32'd0;
    @(negedge CLK);
    chk("rstbusy_state", {30'd0, DbgStateM}, 32'd0);
    chk("rstbusy_rdata", ReadDataM, 32'd0);
    chk("rstbusy_valid", {31'd0, DataValidM}, 32'd0);
    @(posedge CLK); #1;
    access("lw40", 3'b010, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 0, 0, 0, 32'hCAFE_F00D, 4'b1111, 32'd0, 0);

    repeat (2) @(negedge CLK);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
